// File: rtl/mac_pkg.sv
// mac_pkg: RX descriptor field positions, fetch FSM encodings and the stream beat type
package mac_pkg;
  localparam int PTR_LEN_MSB = 11;
  localparam int PTR_CRC_BIT = 12;
  localparam int PTR_TTE_BIT = 13;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PTR_WAIT = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;
  function automatic logic frame_drop(input logic [11:0] len, input logic crc_err, input logic [11:0] max_len);
    return crc_err | (len == 12'd0) | (len > max_len);
  endfunction
endpackage

// File: rtl/rx_fetch_skid.sv
// rx_fetch_skid: two-entry byte buffer between the data FIFO read port and the output stream
module rx_fetch_skid
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rstn_sys,
  input  logic       push_i,
  input  beat_t      beat_i,
  input  logic       ready_i,
  output logic       valid_o,
  output beat_t      beat_o,
  output logic [1:0] count_o
);
  beat_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic pop;
  assign valid_o = cnt_q != 2'd0;
  assign beat_o = valid_o ? e0_q : '0;
  assign count_o = cnt_q;
  // head refills from the second slot or the arriving byte; the head never moves while stalled
  always_comb begin
    pop = valid_o & ready_i;
    e0_d = pop ? (cnt_q == 2'd2 ? e1_q : beat_i) : (cnt_q == 2'd0 ? beat_i : e0_q);
    e1_d = (push_i && cnt_q == (pop ? 2'd2 : 2'd1)) ? beat_i : e1_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
  end
  // entry storage and occupancy
  always_ff @(posedge clk)
    if (!rstn_sys) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rx_frame_fetch.sv
// rx_frame_fetch: pops one RX descriptor at a time and streams the frame's bytes as valid/ready beats;
// frames with a CRC error, zero length or length above MAX_LEN are drained from the data FIFO silently.
// Optional RX_FETCH_STATS_EN adds saturating forwarded/dropped frame counters.
module rx_frame_fetch
  import mac_pkg::*;
#(
  parameter int         MAX_LEN = 1518,
  parameter logic [3:0] PORT_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rstn_sys,
  input  logic        rx_ptr_fifo_empty,
  output logic        rx_ptr_fifo_rd,
  input  logic [19:0] rx_ptr_fifo_dout,
  output logic        rx_data_fifo_rd,
  input  logic [7:0]  rx_data_fifo_dout,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_sop,
  output logic        o_eop,
  output logic [11:0] o_len,
  output logic [1:0]  o_flags,
  output logic [3:0]  o_port
`ifdef RX_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fwd,
  output logic [31:0] stat_drop
`endif
);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  logic [1:0] st_q, st_d;
  logic [11:0] rem_q, rem_d, len_q, len_d;
  logic [1:0] flags_q, flags_d;
  logic infl_q, infl_sop_q, infl_eop_q;
  logic ptr_rd, data_rd, pop, hand_eop, drop_done;
  logic sk_valid;
  beat_t sk_beat, sk_in;
  logic [1:0] sk_cnt;
  logic [2:0] occ;
  logic [11:0] dlen;
  logic unused_rsvd;
  assign unused_rsvd = ^rx_ptr_fifo_dout[19:14];
  assign dlen = rx_ptr_fifo_dout[PTR_LEN_MSB:0];
  assign pop = sk_valid & o_ready;
  assign hand_eop = pop & sk_beat.eop;
  assign occ = {1'b0, sk_cnt} + {2'b0, infl_q};
  assign sk_in = '{data: rx_data_fifo_dout, sop: infl_sop_q, eop: infl_eop_q};
  // frame sequencing; a read may issue only if the byte it returns has a guaranteed skid slot
  always_comb begin
    st_d = st_q;
    rem_d = rem_q;
    len_d = len_q;
    flags_d = flags_q;
    ptr_rd = 1'b0;
    data_rd = 1'b0;
    drop_done = 1'b0;
    case (st_q)
      ST_IDLE: begin
        ptr_rd = !rx_ptr_fifo_empty;
        st_d = ptr_rd ? ST_PTR_WAIT : ST_IDLE;
      end
      ST_PTR_WAIT: begin
        len_d = dlen;
        flags_d = {rx_ptr_fifo_dout[PTR_TTE_BIT], 1'b0};
        rem_d = dlen;
        drop_done = dlen == 12'd0;
        st_d = drop_done ? ST_IDLE : frame_drop(dlen, rx_ptr_fifo_dout[PTR_CRC_BIT], MAX_L) ? ST_DRAIN : ST_XFER;
      end
      ST_XFER: begin
        data_rd = rem_q != 12'd0 && occ < (pop ? 3'd3 : 3'd2);
        rem_d = rem_q - {11'd0, data_rd};
        ptr_rd = hand_eop & !rx_ptr_fifo_empty;
        st_d = ptr_rd ? ST_PTR_WAIT : hand_eop ? ST_IDLE : ST_XFER;
      end
      default: begin
        data_rd = 1'b1;
        rem_d = rem_q - 12'd1;
        drop_done = rem_q == 12'd1;
        st_d = drop_done ? ST_IDLE : ST_DRAIN;
      end
    endcase
  end
  // FSM, frame attributes and the tag of the byte currently in flight from the data FIFO
  always_ff @(posedge clk)
    if (!rstn_sys) begin
      st_q <= ST_IDLE;
      rem_q <= '0;
      len_q <= '0;
      flags_q <= '0;
      infl_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rem_q <= rem_d;
      len_q <= len_d;
      flags_q <= flags_d;
      infl_q <= data_rd & (st_q == ST_XFER);
      infl_sop_q <= rem_q == len_q;
      infl_eop_q <= rem_q == 12'd1;
    end
  rx_fetch_skid u_skid (
    .clk(clk),
    .rstn_sys(rstn_sys),
    .push_i(infl_q),
    .beat_i(sk_in),
    .ready_i(o_ready),
    .valid_o(sk_valid),
    .beat_o(sk_beat),
    .count_o(sk_cnt)
  );
  assign rx_ptr_fifo_rd = ptr_rd & rstn_sys;
  assign rx_data_fifo_rd = data_rd & rstn_sys;
  assign o_valid = sk_valid;
  assign o_data = sk_beat.data;
  assign o_sop = sk_beat.sop;
  assign o_eop = sk_beat.eop;
  assign o_len = len_q;
  assign o_flags = flags_q;
  assign o_port = PORT_ID;
`ifdef RX_FETCH_STATS_EN
  logic [31:0] fwd_q, drop_q;
  // saturating frame counters
  always_ff @(posedge clk)
    if (!rstn_sys) begin
      fwd_q <= '0;
      drop_q <= '0;
    end else begin
      fwd_q <= fwd_q + {31'd0, hand_eop && fwd_q != '1};
      drop_q <= drop_q + {31'd0, drop_done && drop_q != '1};
    end
  assign stat_fwd = fwd_q;
  assign stat_drop = drop_q;
`endif
endmodule

// File: tb/tb_rx_frame_fetch.sv
// tb_rx_frame_fetch: directed and randomized frames checked against a frame-level byte model
`timescale 1ns/1ps
module tb_rx_frame_fetch;
  logic clk = 1'b0, rstn_sys = 1'b0;
  logic rx_ptr_fifo_empty = 1'b1, rx_ptr_fifo_rd, rx_data_fifo_rd;
  logic [19:0] rx_ptr_fifo_dout = '0;
  logic [7:0] rx_data_fifo_dout = '0;
  logic o_valid, o_ready = 1'b0, o_sop, o_eop;
  logic [7:0] o_data;
  logic [11:0] o_len;
  logic [1:0] o_flags;
  logic [3:0] o_port;
`ifdef RX_FETCH_STATS_EN
  logic [31:0] stat_fwd, stat_drop;
`endif
  rx_frame_fetch #(.MAX_LEN(1518), .PORT_ID(4'd0)) dut (
    .clk(clk), .rstn_sys(rstn_sys),
    .rx_ptr_fifo_empty(rx_ptr_fifo_empty), .rx_ptr_fifo_rd(rx_ptr_fifo_rd), .rx_ptr_fifo_dout(rx_ptr_fifo_dout),
    .rx_data_fifo_rd(rx_data_fifo_rd), .rx_data_fifo_dout(rx_data_fifo_dout),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop),
    .o_len(o_len), .o_flags(o_flags), .o_port(o_port)
`ifdef RX_FETCH_STATS_EN
    , .stat_fwd(stat_fwd), .stat_drop(stat_drop)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic [11:0] len;
    logic [1:0]  flags;
  } exp_t;
  logic [19:0] ptr_q[$];
  logic [7:0] data_q[$];
  exp_t exp_q[$];
  logic [7:0] acc_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, data_rds = 0, ptr_rds = 0, beats = 0;
  int model_fwd = 0, model_drop = 0, sop_cyc = 0, eop_cyc = 0, ready_pct = 100;
  logic pr_s = 1'b0, dr_s = 1'b0, ov_s = 1'b0;
  logic pv = 1'b0, prdy = 1'b0, psop = 1'b0, peop = 1'b0;
  logic [7:0] pdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // frame model: bytes go to the data FIFO first, then the descriptor; forwarded bytes become expected beats
  task automatic push_frame(input int len, input bit crc, input bit tte, input bit incr, input int base);
    logic [7:0] b;
    bit fwd;
    fwd = !crc && len != 0 && len <= 1518;
    for (int i = 0; i < len; i++) begin
      b = incr ? 8'(base + i) : 8'($urandom);
      data_q.push_back(b);
      if (fwd) exp_q.push_back('{data: b, sop: i == 0, eop: i == len - 1, len: 12'(len), flags: {tte, 1'b0}});
    end
    ptr_q.push_back({6'($urandom), tte, crc, 12'(len)});
    rx_ptr_fifo_empty = 1'b0;
    if (fwd) model_fwd++;
    else model_drop++;
  endtask

  task automatic compare();
    exp_t e;
    if (!rstn_sys) pv = 1'b0;
    else begin
      if (pv && !prdy) chk("hold", 32'({o_valid, o_data, o_sop, o_eop}), 32'({1'b1, pdata, psop, peop}));
      if (o_valid) chk("port", 32'(o_port), 32'd0);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("beat", 32'({o_data, o_sop, o_eop, o_len, o_flags}), 32'(e));
        end
        acc_q.push_back(o_data);
        beats++;
        if (o_sop) sop_cyc = cyc;
        if (o_eop) eop_cyc = cyc;
      end
      if (rx_data_fifo_rd) chk("data_underflow", 32'(data_q.size() > 0), 32'd1);
      pv = o_valid;
      prdy = o_ready;
      pdata = o_data;
      psop = o_sop;
      peop = o_eop;
    end
  endtask

  // one clock: check outputs mid-cycle, then emulate standard-read FIFOs and drive o_ready
  task automatic tick();
    @(negedge clk);
    compare();
    pr_s = rx_ptr_fifo_rd;
    dr_s = rx_data_fifo_rd;
    ov_s = o_valid;
    @(posedge clk);
    cyc++;
    #1;
    if (pr_s) begin
      ptr_rds++;
      if (ptr_q.size() > 0) rx_ptr_fifo_dout = ptr_q.pop_front();
    end
    if (dr_s) begin
      data_rds++;
      if (data_q.size() > 0) rx_data_fifo_dout = data_q.pop_front();
    end
    rx_ptr_fifo_empty = ptr_q.size() == 0;
    o_ready = int'($urandom_range(99)) < ready_pct;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || data_q.size() > 0 || ptr_q.size() > 0) && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("drained", 32'(exp_q.size() + data_q.size() + ptr_q.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, b0, d0, p0, c1, c2, r, len;
    bit ok;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out", 32'({o_valid, o_sop, o_eop, o_data, o_len, o_flags, rx_ptr_fifo_rd, rx_data_fifo_rd}), 32'd0);
    @(posedge clk);
    #1;
    rstn_sys = 1'b1;
    o_ready = 1'b1;

    b0 = beats;
    t0 = -1;
    t1 = -1;
    push_frame(64, 0, 0, 1, 0);
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      tick();
      if (pr_s && t0 < 0) t0 = cyc;
      if (ov_s) t1 = cyc;
    end
    chk("first_latency", 32'(t1 - t0), 32'd4);
    wait_done(2000);
    chk("beats64", 32'(beats - b0), 32'd64);
    chk("sop_to_eop", 32'(eop_cyc - sop_cyc), 32'd63);

    b0 = beats;
    d0 = data_rds;
    push_frame(64, 1, 0, 0, 0);
    push_frame(60, 0, 1, 0, 0);
    wait_done(2000);
    chk("crc_then_good_rds", 32'(data_rds - d0), 32'd124);
    chk("crc_then_good_beats", 32'(beats - b0), 32'd60);

    b0 = beats;
    d0 = data_rds;
    p0 = ptr_rds;
    push_frame(1600, 0, 0, 0, 0);
    push_frame(1519, 0, 0, 0, 0);
    push_frame(1518, 0, 1, 0, 0);
    wait_done(8000);
    chk("oversize_rds", 32'(data_rds - d0), 32'(1600 + 1519 + 1518));
    chk("oversize_beats", 32'(beats - b0), 32'd1518);
    chk("oversize_ptr_pops", 32'(ptr_rds - p0), 32'd3);

    d0 = data_rds;
    c1 = -1;
    c2 = -1;
    push_frame(0, 0, 0, 0, 0);
    push_frame(5, 0, 0, 1, 8'h40);
    for (int k = 0; k < 20 && c2 < 0; k++) begin
      tick();
      if (pr_s) begin
        if (c1 < 0) c1 = cyc;
        else c2 = cyc;
      end
    end
    chk("len0_gap", 32'(c2 - c1), 32'd2);
    wait_done(200);
    chk("len0_rds", 32'(data_rds - d0), 32'd5);

    acc_q.delete();
    ready_pct = 50;
    push_frame(100, 0, 0, 1, 0);
    wait_done(3000);
    ok = acc_q.size() == 100;
    for (int i = 0; i < acc_q.size(); i++) ok &= acc_q[i] == 8'(i);
    chk("order100", 32'(ok), 32'd1);

    acc_q.delete();
    ready_pct = 100;
    push_frame(1, 0, 0, 1, 8'hAA);
    push_frame(1, 0, 0, 1, 8'hBB);
    push_frame(1, 0, 0, 1, 8'hCC);
    wait_done(200);
    chk("b2b_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 3) chk("b2b_bytes", 32'({acc_q[0], acc_q[1], acc_q[2]}), 32'hAABBCC);

    for (int f = 0; f < 60; f++) begin
      r = int'($urandom_range(99));
      len = r < 6 ? 0 : r < 10 ? int'($urandom_range(1700, 1519)) : r < 12 ? 1518 : int'($urandom_range(120, 1));
      push_frame(len, $urandom_range(9) == 0, 1'($urandom_range(1)), 0, 0);
      r = int'($urandom_range(2));
      ready_pct = r == 0 ? 100 : r == 1 ? 70 : 30;
      repeat ($urandom_range(40)) tick();
    end
    wait_done(40000);

    ready_pct = 100;
    b0 = beats;
    push_frame(64, 0, 1, 1, 0);
    push_frame(10, 0, 0, 1, 0);
    for (int k = 0; k < 300 && beats < b0 + 30; k++) tick();
    chk("reached30", 32'(beats - b0), 32'd30);
    rstn_sys = 1'b0;
    tick();
    @(negedge clk);
    chk("midframe_reset", 32'({o_valid, o_sop, o_eop, o_data, o_len, o_flags, rx_ptr_fifo_rd, rx_data_fifo_rd}), 32'd0);
`ifdef RX_FETCH_STATS_EN
    chk("stats_reset", {stat_fwd[15:0], stat_drop[15:0]}, 32'd0);
`endif
    ptr_q.delete();
    data_q.delete();
    exp_q.delete();
    rx_ptr_fifo_empty = 1'b1;
    model_fwd = 0;
    model_drop = 0;
    @(posedge clk);
    #1;
    rstn_sys = 1'b1;
    b0 = beats;
    push_frame(8, 0, 0, 1, 8'h10);
    wait_done(200);
    chk("after_reset_beats", 32'(beats - b0), 32'd8);
`ifdef RX_FETCH_STATS_EN
    chk("stat_fwd", stat_fwd, 32'(model_fwd));
    chk("stat_drop", stat_drop, 32'(model_drop));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
